// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, valid/ready handshakes on request and response sides,
// one operation in flight at a time. ALU inputs are registered at the accept
// edge and held for ALU_LAT cycles before z/flags are captured.
// Optional feature macro: ALU_ARB_PERF_EN builds two 16-bit saturating grant
// counters on perf_cnt; when undefined perf_cnt is tied to zero.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [17:0]        req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_z,
    output logic [2:0]         rsp_flags,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [8:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_z,
    input  logic               alu_ovf,
    input  logic               alu_zero,
    input  logic               alu_cflag,
    output logic [31:0]        perf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [8:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   rsp_z_q, rsp_z_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic               grant;
    logic               accept;

    // Pick the requester to serve: the only valid one, or the one not served last on a tie.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end
    end

    // NOTE: rst_n gates the accept so req_ready stays low while reset is held,
    // even though the state register already reads IDLE.
    assign accept = rst_n && (state_q == S_IDLE) && (req_valid != 2'b00);

    // Next-state and datapath-register update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_z_d      = rsp_z_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready    = grant ? 2'b10 : 2'b01;
                    alu_a_d      = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    alu_b_d      = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    alu_op_d     = grant ? req_op[17:9] : req_op[8:0];
                    last_grant_d = grant;
                    lat_cnt_d    = LAT_INIT;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    rsp_z_d     = alu_z;
                    rsp_flags_d = {alu_ovf, alu_zero, alu_cflag};
                    state_d     = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = last_grant_q ? 2'b10 : 2'b01;
                if (rsp_ready[last_grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            lat_cnt_q    <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_z_q      <= '0;
            rsp_flags_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_z_q      <= rsp_z_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grants0_q;
    logic [15:0] grants1_q;

    // Saturating per-requester grant counters, bumped on each accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants0_q <= 16'h0000;
            grants1_q <= 16'h0000;
        end else if (accept) begin
            if (!grant && (grants0_q != 16'hFFFF)) begin
                grants0_q <= grants0_q + 16'd1;
            end
            if (grant && (grants1_q != 16'hFFFF)) begin
                grants1_q <= grants1_q + 16'd1;
            end
        end
    end

    assign perf_cnt = {grants1_q, grants0_q};
`else
    assign perf_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small add/sub ALU stub.
module tb_alu_arbiter;

    localparam int WIDTH   = 32;
    localparam int ALU_LAT = 1;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [17:0]        req_op;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_z;
    logic [2:0]         rsp_flags;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [8:0]         alu_op;
    logic [WIDTH-1:0]   alu_z;
    logic               alu_ovf;
    logic               alu_zero;
    logic               alu_cflag;
    logic [31:0]        perf_cnt;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_ovf   (alu_ovf),
        .alu_zero  (alu_zero),
        .alu_cflag (alu_cflag),
        .perf_cnt  (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: AddSel=0 add, AddSel=1 subtract; cflag is carry (add) or borrow (sub).
    logic [WIDTH:0] alu_wide;
    always_comb begin
        if (alu_op[0]) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        else           alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_z     = alu_wide[WIDTH-1:0];
    assign alu_cflag = alu_wide[WIDTH];
    assign alu_zero  = (alu_z == '0);
    assign alu_ovf   = alu_op[0]
                     ? ((alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_z[WIDTH-1] != alu_a[WIDTH-1]))
                     : ((alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_z[WIDTH-1] != alu_a[WIDTH-1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [8:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[r*9 +: 9]       = op;
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Single request, rsp_ready held high: checks grant, held operands, latency and result.
    task automatic run_single(input int r, input logic [8:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_z,
                              input logic [2:0] exp_f, input string tag);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        set_req(r, op, a, b);
        rsp_ready = 2'b11;
        req_valid = oh;
        #1;
        check({tag, "_req_ready"}, req_ready, oh);
        step();
        req_valid = 2'b00;
        #1;
        check({tag, "_exec_ready"}, req_ready, 2'b00);
        check({tag, "_exec_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_op"}, alu_op, op);
        step();
        check({tag, "_rsp_valid"}, rsp_valid, oh);
        check({tag, "_rsp_z"}, rsp_z, exp_z);
        check({tag, "_rsp_flags"}, rsp_flags, exp_f);
        step();
        check({tag, "_rsp_done"}, rsp_valid, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [31:0] exp_perf;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with both requests asserted during reset.
        step();
        step();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_z", rsp_z, 32'h0);
        check("rst_rsp_flags", rsp_flags, 3'b000);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_op", alu_op, 9'h0);
        check("rst_perf", perf_cnt, 32'h0);
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Basic add and subtract-to-zero on requester 0.
        run_single(0, 9'h000, 32'h14, 32'h35, 32'h49, 3'b000, "add0");
        check("idle_alu_a_held", alu_a, 32'h14);
        check("idle_alu_b_held", alu_b, 32'h35);
        run_single(0, 9'h001, 32'h0, 32'h0, 32'h0, 3'b010, "sub0");

        // Both valid continuously from reset: strict alternation starting with req0.
        do_reset();
        set_req(0, 9'h000, 32'd100, 32'd5);
        set_req(1, 9'h000, 32'd7, 32'd9);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            g = 0;
            for (int i = 0; i < 10 && req_ready == 2'b00; i++) step();
            check("rr_grant_seen", (req_ready != 2'b00), 1'b1);
            g = req_ready[1] ? 1 : 0;
            check("rr_grant_order", g, k % 2);
            step();
            for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) step();
            check("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
            check("rr_rsp_z", rsp_z, (k % 2 == 1) ? 32'd16 : 32'd105);
            step();
            if (k == 7) req_valid = 2'b00;
        end
`ifdef ALU_ARB_PERF_EN
        exp_perf = 32'h0004_0004;
`else
        exp_perf = 32'h0;
`endif
        check("rr_perf", perf_cnt, exp_perf);

        // Response backpressure: result held, requester 1 waits until accept.
        rsp_ready = 2'b00;
        set_req(0, 9'h000, 32'h1, 32'h2);
        set_req(1, 9'h000, 32'h10, 32'h20);
        req_valid = 2'b01;
        #1;
        check("bp_ready0", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        step();
        for (int i = 0; i < 5; i++) begin
            rsp_ready = 2'b10;
            #1;
            check("bp_rsp_valid", rsp_valid, 2'b01);
            check("bp_rsp_z", rsp_z, 32'h3);
            check("bp_req_ready", req_ready, 2'b00);
            step();
        end
        rsp_ready = 2'b01;
        step();
        check("bp_after_rsp_valid", rsp_valid, 2'b00);
        check("bp_req1_granted", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step();
        check("bp_req1_rsp_valid", rsp_valid, 2'b10);
        check("bp_req1_rsp_z", rsp_z, 32'h30);
        step();

        // Reset while in EXEC: outputs clear at once, no stale response, req0 wins tie.
        set_req(0, 9'h000, 32'h55, 32'h1);
        set_req(1, 9'h000, 32'h2, 32'h3);
        req_valid = 2'b01;
        #1;
        check("mr_ready0", req_ready, 2'b01);
        step();
        req_valid = 2'b11;
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_req_ready", req_ready, 2'b00);
        check("mr_rsp_valid", rsp_valid, 2'b00);
        check("mr_rsp_z", rsp_z, 32'h0);
        check("mr_alu_a", alu_a, 32'h0);
        check("mr_alu_op", alu_op, 9'h0);
        check("mr_perf", perf_cnt, 32'h0);
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_no_rsp", rsp_valid, 2'b00);
        end
        req_valid = 2'b11;
        #1;
        check("mr_tie_req0", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        check("mr_new_rsp_valid", rsp_valid, 2'b01);
        check("mr_new_rsp_z", rsp_z, 32'h56);
        step();

        // Grant counters: 3 grants to req1, 2 to req0.
        do_reset();
        run_single(1, 9'h000, 32'd1, 32'd1, 32'd2, 3'b000, "pf1a");
        run_single(1, 9'h000, 32'd2, 32'd1, 32'd3, 3'b000, "pf1b");
        run_single(0, 9'h000, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b011, "pf0a");
        run_single(1, 9'h001, 32'd1, 32'd2, 32'hFFFF_FFFF, 3'b001, "pf1c");
        run_single(0, 9'h001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b100, "pf0b");
`ifdef ALU_ARB_PERF_EN
        exp_perf = 32'h0003_0002;
`else
        exp_perf = 32'h0;
`endif
        check("perf_cnt", perf_cnt, exp_perf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
